// File: rtl/aes_stream_sequencer.sv
// Bus-master front end for the aes register core: loads the key schedule,
// then turns each plaintext stream beat into one register-level encryption.
module aes_stream_sequencer #(
  parameter int POLL_LIMIT    = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic         key_load,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         error,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data
);

  localparam logic [7:0]  ADDR_CTRL    = 8'h08;
  localparam logic [7:0]  ADDR_STATUS  = 8'h09;
  localparam logic [7:0]  ADDR_CONFIG  = 8'h0a;
  localparam logic [7:0]  ADDR_KEY0    = 8'h10;
  localparam logic [7:0]  ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0]  ADDR_RESULT0 = 8'h30;
  localparam logic [15:0] POLL_LAST    = 16'(POLL_LIMIT - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY_WR, S_CFG_INIT, S_CTRL_INIT, S_SETTLE_INIT, S_POLL_INIT,
    S_READY, S_BLK_WR, S_CFG_ENC, S_CTRL_NEXT, S_SETTLE_ENC, S_POLL_VALID,
    S_RES_RD, S_OUT, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [255:0]   key_q, key_d;
  logic           keylen_q, keylen_d;
  logic [127:0]   block_q, block_d;
  logic [127:0]   result_q, result_d;
  logic           keyLoadOk;
  logic           inFire;
  logic [7:0]     keyBase;
  logic [6:0]     wordBase;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      keylen_q <= 1'b0;
      block_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      keylen_q <= keylen_d;
      block_q  <= block_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    keylen_d   = keylen_q;
    block_d    = block_q;
    result_d   = result_q;
    cs         = 1'b0;
    we         = 1'b0;
    address    = 8'h00;
    write_data = 32'h0;
    keyBase    = {3'd7 - cnt_q[2:0], 5'd0};
    wordBase   = {2'd3 - cnt_q[1:0], 5'd0};
    keyLoadOk  = key_load && (state_q inside {S_IDLE, S_READY, S_ERROR});
    in_ready   = (state_q == S_READY) && !key_load;
    inFire     = in_valid && in_ready;

    case (state_q)
      S_KEY_WR: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_KEY0 + {5'd0, cnt_q[2:0]};
        write_data = (!keylen_q && cnt_q[2]) ? 32'h0 : key_q[keyBase +: 32];
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q[2:0] == 3'd7) begin
          state_d = S_CFG_INIT;
          cnt_d   = '0;
        end
      end
      S_CFG_INIT: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CONFIG;
        write_data = {30'b0, keylen_q, 1'b0};
        state_d    = S_CTRL_INIT;
      end
      S_CTRL_INIT: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CTRL;
        write_data = 32'h1;
        cnt_d      = '0;
        state_d    = (SETTLE_CYCLES == 0) ? S_POLL_INIT : S_SETTLE_INIT;
      end
      S_SETTLE_INIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_POLL_INIT;
          cnt_d   = '0;
        end
      end
      // Status is sampled at the edge that ends the read cycle.
      S_POLL_INIT: begin
        cs      = 1'b1;
        address = ADDR_STATUS;
        cnt_d   = cnt_q + 16'd1;
        if (read_data[0]) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else if (cnt_q == POLL_LAST) begin
          state_d = S_ERROR;
          cnt_d   = '0;
        end
      end
      S_READY: begin
        if (inFire) begin
          block_d = in_data;
          state_d = S_BLK_WR;
          cnt_d   = '0;
        end
      end
      S_BLK_WR: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_BLOCK0 + {6'd0, cnt_q[1:0]};
        write_data = block_q[wordBase +: 32];
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q[1:0] == 2'd3) begin
          state_d = S_CFG_ENC;
          cnt_d   = '0;
        end
      end
      S_CFG_ENC: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CONFIG;
        write_data = {30'b0, keylen_q, 1'b1};
        state_d    = S_CTRL_NEXT;
      end
      S_CTRL_NEXT: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = ADDR_CTRL;
        write_data = 32'h2;
        cnt_d      = '0;
        state_d    = (SETTLE_CYCLES == 0) ? S_POLL_VALID : S_SETTLE_ENC;
      end
      S_SETTLE_ENC: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_POLL_VALID;
          cnt_d   = '0;
        end
      end
      S_POLL_VALID: begin
        cs      = 1'b1;
        address = ADDR_STATUS;
        cnt_d   = cnt_q + 16'd1;
        if (read_data[1:0] == 2'b11) begin
          state_d = S_RES_RD;
          cnt_d   = '0;
        end else if (cnt_q == POLL_LAST) begin
          state_d = S_ERROR;
          cnt_d   = '0;
        end
      end
      S_RES_RD: begin
        cs                   = 1'b1;
        address              = ADDR_RESULT0 + {6'd0, cnt_q[1:0]};
        result_d[wordBase +: 32] = read_data;
        cnt_d                = cnt_q + 16'd1;
        if (cnt_q[1:0] == 2'd3) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_READY;
      end
      default: ;
    endcase

    // A key load restarts the schedule and wins over a coincident block.
    if (keyLoadOk) begin
      key_d    = key;
      keylen_d = keylen;
      state_d  = S_KEY_WR;
      cnt_d    = '0;
    end
  end

  assign busy      = !(state_q inside {S_IDLE, S_READY, S_ERROR});
  assign error     = (state_q == S_ERROR);
  assign key_ready = state_q inside {S_READY, S_BLK_WR, S_CFG_ENC, S_CTRL_NEXT,
                                     S_SETTLE_ENC, S_POLL_VALID, S_RES_RD, S_OUT};
  assign out_valid = (state_q == S_OUT);
  assign out_data  = result_q;

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Directed bench for aes_stream_sequencer with a register-level stub of the aes
// core that returns known-answer ciphertexts for the exact key/block it was given.
module tb_aes_stream_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] key = '0;
  logic         keylen = 1'b0;
  logic         key_load = 1'b0;
  logic         key_ready;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic         error;
  logic         cs;
  logic         we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'hffeeddccbbaa99887766554433221100};
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K3 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P3A = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P3B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  always #5 clk = ~clk;

  aes_stream_sequencer #(.POLL_LIMIT(64), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .key(key), .keylen(keylen), .key_load(key_load),
    .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .error(error), .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data)
  );

  // Core stub state; only known-answer vectors produce a real ciphertext.
  logic [31:0]  keyW [8];
  logic [31:0]  blkW [4];
  logic [31:0]  cfgReg = '0;
  logic [127:0] resReg = '0;
  logic         rdyFlag = 1'b0;
  logic         valFlag = 1'b0;
  int           busyCnt = 0;
  int           stubDelay = 0;
  bit           stuck = 1'b0;
  int           busCount = 0;
  int           statusReads = 0;
  logic [31:0]  keyLog [$];
  logic [31:0]  cfgLog [$];
  logic [31:0]  ctrlLog [$];

  function automatic logic [127:0] lookup(input logic [255:0] k, input logic [127:0] pt,
                                          input logic [31:0] cfg);
    if (cfg[0] !== 1'b1) return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
    if (cfg[1] === 1'b0 && k[127:0] === 128'h0) begin
      if (k[255:128] === K1[255:128] && pt === P1) return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      if (k[255:128] === K3[255:128] && pt === P3A) return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      if (k[255:128] === K3[255:128] && pt === P3B) return 128'hf5d3d58503b9699de785895a96fdbaaf;
    end
    if (cfg[1] === 1'b1 && k === K2 && pt === P1) return 128'h8ea2b7ca516745bfeafc49904b496089;
    return 128'hbad1bad1bad1bad1bad1bad1bad1bad1;
  endfunction

  always_comb begin
    read_data = 32'h0;
    if (cs && !we) begin
      case (address)
        8'h09: read_data = (stuck || busyCnt != 0) ? 32'h0 : {30'b0, valFlag, rdyFlag};
        8'h30: read_data = resReg[127:96];
        8'h31: read_data = resReg[95:64];
        8'h32: read_data = resReg[63:32];
        8'h33: read_data = resReg[31:0];
        default: read_data = 32'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (busyCnt > 0) busyCnt <= busyCnt - 1;
    if (cs) begin
      busCount <= busCount + 1;
      if (we) begin
        if (address >= 8'h10 && address <= 8'h17) begin
          keyW[address[2:0]] <= write_data;
          keyLog.push_back(write_data);
        end else if (address >= 8'h20 && address <= 8'h23) begin
          blkW[address[1:0]] <= write_data;
        end else if (address == 8'h0a) begin
          cfgReg <= write_data;
          cfgLog.push_back(write_data);
        end else if (address == 8'h08) begin
          ctrlLog.push_back(write_data);
          busyCnt <= stubDelay;
          if (write_data[1]) begin
            resReg  <= lookup({keyW[0], keyW[1], keyW[2], keyW[3], keyW[4], keyW[5], keyW[6], keyW[7]},
                              {blkW[0], blkW[1], blkW[2], blkW[3]}, cfgReg);
            rdyFlag <= 1'b1;
            valFlag <= 1'b1;
          end else if (write_data[0]) begin
            rdyFlag <= 1'b1;
            valFlag <= 1'b0;
          end
        end
      end else if (address == 8'h09) begin
        statusReads <= statusReads + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitKeyReady(input string name);
    for (int i = 0; i < 2000 && key_ready !== 1'b1; i++) step();
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_key_ready_timeout: key_ready=%b required 1", name, key_ready);
    end
  endtask

  task automatic loadKey(input logic [255:0] k, input logic kl, input string name);
    key = k;
    keylen = kl;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    waitKeyReady(name);
  endtask

  task automatic runBlock(input logic [127:0] pt, output logic [127:0] ct, output int lat);
    for (int i = 0; i < 2000 && in_ready !== 1'b1; i++) step();
    in_data = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 2000) begin
      step();
      lat++;
    end
    ct = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({cs, we, busy, error, key_ready, in_ready, out_valid} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b required 0000000",
               {cs, we, busy, error, key_ready, in_ready, out_valid});
    end
    checks++;
    if (address !== 8'h0 || write_data !== 32'h0 || out_data !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: address=%h write_data=%h out_data=%h required all 0",
               address, write_data, out_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_key128();
    int k0, c0, f0, lat;
    logic [127:0] ct;
    logic [255:0] kv;
    logic [31:0] expWord;
    bit bad;
    k0 = keyLog.size();
    c0 = cfgLog.size();
    f0 = ctrlLog.size();
    stubDelay = 3;
    key = K1;
    keylen = 1'b0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL k128_busy: busy=%b key_ready=%b required 1 0", busy, key_ready);
    end
    waitKeyReady("k128");
    kv = K1;
    bad = 1'b0;
    if (keyLog.size() - k0 != 8) bad = 1'b1;
    else for (int i = 0; i < 8; i++) begin
      expWord = (i < 4) ? kv[255 - 32*i -: 32] : 32'h0;
      if (keyLog[k0 + i] !== expWord) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL k128_key_words: count=%0d required 8 with words 4..7 zero", keyLog.size() - k0);
    end
    checks++;
    if (cfgLog.size() - c0 != 1 || cfgLog[cfgLog.size()-1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL k128_cfg_init: got %h required 00000000", cfgLog[cfgLog.size()-1]);
    end
    checks++;
    if (ctrlLog.size() - f0 != 1 || ctrlLog[ctrlLog.size()-1] !== 32'h1) begin
      errors++;
      $display("[TB] FAIL k128_ctrl_init: got %h required 00000001", ctrlLog[ctrlLog.size()-1]);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL k128_in_ready: got %b required 1", in_ready);
    end
    stubDelay = 0;
    runBlock(P1, ct, lat);
    checks++;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      errors++;
      $display("[TB] FAIL k128_cipher: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
    end
    checks++;
    if (lat != 14) begin
      errors++;
      $display("[TB] FAIL k128_latency: got %0d required 14", lat);
    end
    checks++;
    if (cfgLog[cfgLog.size()-1] !== 32'h1 || ctrlLog[ctrlLog.size()-1] !== 32'h2) begin
      errors++;
      $display("[TB] FAIL k128_enc_writes: cfg=%h ctrl=%h required 1 2",
               cfgLog[cfgLog.size()-1], ctrlLog[ctrlLog.size()-1]);
    end
  endtask

  task automatic test_key256();
    int c0, lat;
    logic [127:0] ct;
    c0 = cfgLog.size();
    stubDelay = 4;
    loadKey(K2, 1'b1, "k256");
    runBlock(P1, ct, lat);
    checks++;
    if (cfgLog.size() - c0 != 2 || cfgLog[c0] !== 32'h2 || cfgLog[c0+1] !== 32'h3) begin
      errors++;
      $display("[TB] FAIL k256_cfg: got %h %h required 00000002 00000003", cfgLog[c0], cfgLog[c0+1]);
    end
    checks++;
    if (ct !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
      errors++;
      $display("[TB] FAIL k256_cipher: got %h required 8ea2b7ca516745bfeafc49904b496089", ct);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] ct;
    stubDelay = 0;
    loadKey(K3, 1'b0, "b2b");
    runBlock(P3A, ct, lat);
    checks++;
    if (ct !== 128'h3ad77bb40d7a3660a89ecaf32466ef97 || lat != 14) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h lat %0d required 3ad77bb40d7a3660a89ecaf32466ef97 lat 14", ct, lat);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_in_ready_after_out: got %b required 1", in_ready);
    end
    runBlock(P3B, ct, lat);
    checks++;
    if (ct !== 128'hf5d3d58503b9699de785895a96fdbaaf) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h required f5d3d58503b9699de785895a96fdbaaf", ct);
    end
  endtask

  task automatic test_out_hold();
    logic [127:0] held, ct;
    int bc, lat;
    bit bad;
    in_data = P3A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) step();
    held = out_data;
    bc = busCount;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        key = '0;
        key_load = 1'b1;
      end
      step();
      key_load = 1'b0;
      if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    key = K3;
    checks++;
    if (bad || held !== 128'h3ad77bb40d7a3660a89ecaf32466ef97) begin
      errors++;
      $display("[TB] FAIL hold_stable: out_data=%h out_valid=%b in_ready=%b required 3ad77bb40d7a3660a89ecaf32466ef97 1 0",
               out_data, out_valid, in_ready);
    end
    checks++;
    if (busCount != bc) begin
      errors++;
      $display("[TB] FAIL hold_bus_quiet: got %0d accesses required 0", busCount - bc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || key_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release: in_ready=%b key_ready=%b required 1 1", in_ready, key_ready);
    end
    runBlock(P3B, ct, lat);
    checks++;
    if (ct !== 128'hf5d3d58503b9699de785895a96fdbaaf) begin
      errors++;
      $display("[TB] FAIL hold_key_kept: got %h required f5d3d58503b9699de785895a96fdbaaf", ct);
    end
  endtask

  task automatic test_key_priority();
    in_data = P3A;
    in_valid = 1'b1;
    key = K3;
    keylen = 1'b0;
    key_load = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_in_ready: got %b required 0", in_ready);
    end
    step();
    key_load = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_key_load: busy=%b key_ready=%b required 1 0", busy, key_ready);
    end
    waitKeyReady("prio");
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_no_block: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    int s0;
    stuck = 1'b1;
    s0 = statusReads;
    key = K1;
    keylen = 1'b0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 0; i < 1000 && error !== 1'b1; i++) step();
    checks++;
    if (error !== 1'b1 || key_ready !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_flags: error=%b key_ready=%b in_ready=%b out_valid=%b busy=%b required 1 0 0 0 0",
               error, key_ready, in_ready, out_valid, busy);
    end
    checks++;
    if (statusReads - s0 != 64) begin
      errors++;
      $display("[TB] FAIL timeout_reads: got %0d required 64", statusReads - s0);
    end
    step();
    step();
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: got %b required 1", error);
    end
    stuck = 1'b0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got %b required 0", error);
    end
    waitKeyReady("timeout_reload");
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [127:0] ct;
    in_data = P1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !(cs === 1'b1 && address === 8'h32); i++) step();
    checks++;
    if (address !== 8'h32) begin
      errors++;
      $display("[TB] FAIL midreset_reach_rd: address=%h required 32", address);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (cs !== 1'b0 || out_valid !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_idle: cs=%b out_valid=%b key_ready=%b busy=%b error=%b required all 0",
               cs, out_valid, key_ready, busy, error);
    end
    step();
    step();
    checks++;
    if (cs !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: cs=%b out_data=%h required 0 0", cs, out_data);
    end
    loadKey(K1, 1'b0, "midreset");
    runBlock(P1, ct, lat);
    checks++;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      errors++;
      $display("[TB] FAIL midreset_cipher: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
    end
  endtask

  initial begin
    test_reset();
    test_key128();
    test_key256();
    test_back_to_back();
    test_out_hold();
    test_key_priority();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_stream_sequencer.md
Name: aes_stream_sequencer

Overview:
- Bus-master front end for the `aes` register core. It accepts plaintext blocks on a valid/ready stream and drives the core's cs/we/address/write_data/read_data port to load the key, write the block, start encryption, poll status and read the result.
- It returns ciphertext on an output valid/ready stream.
- It replaces software register sequencing when the core is embedded in a datapath.
- Encrypt-only. One block in flight at a time.

Parameters:
- POLL_LIMIT, 64, maximum status reads per poll phase before the block enters ERROR.
- SETTLE_CYCLES, 2, idle cycles after any CTRL write before the first STATUS read.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key  in  256  key value, MSW first; 128-bit mode uses key[255:128].
- keylen  in  1  0 = 128-bit key, 1 = 256-bit key.
- key_load  in  1  one-cycle pulse that starts a key load; honoured only in IDLE, READY or ERROR.
- key_ready  out  1  key schedule initialised; blocks are accepted.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  plaintext accept.
- in_data  in  128  plaintext block.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  ciphertext accept.
- out_data  out  128  ciphertext block.
- busy  out  1  high in every state except IDLE, READY and ERROR.
- error  out  1  poll timeout; sticky until reset or key_load.
- cs  out  1  core chip select.
- we  out  1  core write enable.
- address  out  8  core register address.
- write_data  out  32  core write data.
- read_data  in  32  core read data; combinational from address while cs=1 and we=0, sampled at the rising edge ending that cycle.

Behaviour:
- Core register map:
  - CTRL 0x08: bit0 = init, bit1 = next.
  - STATUS 0x09: bit0 = ready, bit1 = valid.
  - CONFIG 0x0a: bit0 = encdec, bit1 = keylen.
  - KEY0..7 0x10..0x17.
  - BLOCK0..3 0x20..0x23.
  - RESULT0..3 0x30..0x33.
- Bus access rules:
  - Each access occupies exactly one cycle with cs=1; accesses may be back-to-back.
  - When idle: cs=0, we=0, address=0, write_data=0.
- Reset values (take effect one cycle after reset is sampled high): state IDLE; every output 0; internal key, block and result registers cleared. Reset mid-transaction abandons it with no further bus access.
- Word order: MSW to the lowest address, i.e. key[255:224] to 0x10 and in_data[127:96] to 0x20. RESULT0 fills out_data[127:96].
- key_load captures key and keylen, then sequences:
  - KEY_WR: 8 writes to 0x10..0x17. In 128-bit mode words 4..7 are written as 0.
  - CFG_INIT: write CONFIG = {30'b0, keylen, 1'b0}.
  - CTRL_INIT: write CTRL = 0x1.
  - SETTLE: SETTLE_CYCLES idle cycles.
  - POLL_INIT: read STATUS each cycle until bit0 = 1, then go to READY.
- READY:
  - key_ready = 1 and in_ready = 1.
  - A handshake (in_valid & in_ready) captures in_data; in_ready drops the next cycle.
  - key_ready stays 1 through block processing and clears only on key_load, reset or error.
- Block sequence from READY:
  - BLK_WR: 4 writes to 0x20..0x23.
  - CFG_ENC: write CONFIG = {30'b0, keylen, 1'b1}.
  - CTRL_NEXT: write CTRL = 0x2.
  - SETTLE.
  - POLL_VALID: read STATUS until bit0 = 1 and bit1 = 1.
  - RES_RD: 4 reads of 0x30..0x33.
  - OUT: out_valid = 1.
- Latency: in the cycle after the in handshake, the first BLOCK0 write is on the bus. Minimum latency from the in handshake to out_valid is 6 + SETTLE_CYCLES + 1 + 4 + 1 cycles.
- OUT holds out_valid and out_data stable until out_ready. On the handshake it returns to READY, with in_ready high the next cycle. No new block is accepted while OUT is held.
- Timeout: a poll phase that reaches POLL_LIMIT reads without success goes to ERROR:
  - error = 1, key_ready = 0, in_ready = 0, out_valid = 0.
  - Only key_load or reset exits ERROR.
- key_load while busy or in OUT is ignored.
- key_load coincident with in_valid in READY: key_load wins and no block is accepted.
- If key_load is ignored, nothing about it is retained.

Test Plan:
1. Reset, then key_load with key[255:128] = 000102030405060708090a0b0c0d0e0f, keylen = 0 -> bus shows KEY writes 0x10..0x17 (words 4..7 = 0), CONFIG = 0x0, CTRL = 0x1, and key_ready rises. Then in_data = 00112233445566778899aabbccddeeff -> out_data = 69c4e0d86a7b0430d8cdb78070b4c55a; CONFIG write = 0x1, CTRL write = 0x2.
2. keylen = 1, key = 000102...1f -> CONFIG writes 0x2 then 0x3; the same plaintext gives 8ea2b7ca516745bfeafc49904b496089.
3. Back-to-back: key 2b7e151628aed2a6abf7158809cf4f3c, blocks 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 -> 3ad77bb40d7a3660a89ecaf32466ef97 then f5d3d58503b9699de785895a96fdbaaf, in order.
4. out_ready held low 20 cycles -> out_data stable, in_ready = 0, no bus activity. Release -> in_ready = 1 the next cycle.
5. Stub core whose STATUS stays 0, POLL_LIMIT = 64 -> exactly 64 STATUS reads, then error = 1 and key_ready = 0. A following key_load clears error and reloads.
6. Reset asserted during RES_RD -> next cycle cs = 0, out_valid = 0, key_ready = 0, state IDLE. Reload and re-run scenario 1 -> correct ciphertext.
